up_down_311: RTL and testbench
==============================

// Module: up_down_311
// PURPOSE
//   Synchronous 4-bit binary up/down counter with an asynchronous active-high reset.
//   A single direction input selects increment or decrement on every rising clock edge.
//   The count wraps modulo 2^WIDTH in both directions.
//   Leaf block used as a general-purpose event/sequence counter and as a lab reference counter.
// PARAMETERS
//   WIDTH   4   counter width in bits; count_311 spans [WIDTH-1:0], default gives modulo-16
// PORTS
//   clk_311    input   1      system clock; all state changes on rising edge
//   reset_311  input   1      reset, asynchronous, active-high; forces count_311 to 0
//   ud_311     input   1      direction: 1 = count up, 0 = count down
//   count_311  output  WIDTH  current count, driven directly from the state register
// BEHAVIOUR
//   Clocking and reset:
//   - One clock (clk_311); reset (reset_311) is asynchronous and active-high.
//   - reset_311=1: count_311 goes to 0 immediately, without waiting for a clock edge.
//   - count_311 holds 0 while reset_311 is high, regardless of clk_311 or ud_311.
//   - Reset deassertion is not synchronised inside the block; it must meet recovery/removal
//     at the system level.
//   - First rising edge after reset release applies one step: 1 if ud_311=1, 15 if ud_311=0.
//   Counting:
//   - On each rising clk_311 edge with reset_311=0:
//     ud_311=1 -> count <= count + 1;  ud_311=0 -> count <= count - 1.
//   - Arithmetic is unsigned, truncated to WIDTH bits (no saturation, no enable).
//     Up: 15 -> 0.  Down: 0 -> 15.
//   - ud_311 is sampled only at the rising edge. Changing it between edges has no effect
//     until the next edge.
//   - A direction change takes effect on the very next edge. There is no extra latency and
//     no skipped or repeated value: e.g. 5 (up) then ud=0 gives 4.
//   - Output latency: count_311 updates at the clock edge (registered output);
//     no combinational path from ud_311 to count_311.
//   Simultaneous events:
//   - Reset asserted coincident with a clock edge: reset wins, count_311 = 0.
//   - Reset asserted mid-operation: count is lost and counting restarts from 0 after release.
//   Other:
//   - No other state is held; count_311 is fully determined by reset and edge history.
//   - Operation is valid at clock periods down to 1 ns in simulation (unit 1 ns, precision 1 ps).
// TESTING
//   1. Reset:
//      clk period 1 ns, reset_311=1 for first 8 ns with ud_311=1
//      -> count_311=0 throughout, including while clk toggles.
//   2. Up count:
//      release reset at t=8 ns, ud_311=1
//      -> count_311 = 1,2,3,... on successive rising edges; after 15 the next edge gives 0.
//   3. Direction change:
//      at t=108 ns set ud_311=0
//      -> the next edge yields (previous value - 1) mod 16, then keeps decrementing.
//   4. Down wrap:
//      continue ud_311=0 -> ...,2,1,0,15,14,... with no hold at 0.
//   5. Async reset mid-count:
//      assert reset_311 between clock edges while count_311 is nonzero
//      -> count_311=0 before the next edge; after release, counting resumes from 0.
//   6. Run 3000 ns of down-counting and check against a reference model:
//      -> every edge matches (count-1) mod 16, and no X/Z appears on count_311 after reset.

Source files
------------

// File: rtl/up_down_311.sv
// up_down_311: WIDTH-bit binary up/down counter, modulo 2^WIDTH in both directions.
// Asynchronous active-high reset; the count is held directly in the output register.
`timescale 1ns / 1ps

module up_down_311 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_311,
    input  logic             reset_311,
    input  logic             ud_311,
    output logic [WIDTH-1:0] count_311
);

    localparam int unsigned CNT_W = WIDTH;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: unsigned step in the sampled direction; wraps by truncation.
    always_comb begin
        count_d = count_q;
        if (ud_311) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_311 or posedge reset_311) begin
        if (reset_311) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_311 = count_q;

endmodule

// File: tb/tb_up_down_311.sv
// Directed bench for up_down_311: reset, up run with wrap, direction change,
// down wrap, async reset mid-count, reset on a clock edge, long down run.
`timescale 1ns / 1ps

module tb_up_down_311;

    logic       clk_311;
    logic       reset_311;
    logic       ud_311;
    logic [3:0] count_311;

    int unsigned n_vec;
    int unsigned n_err;
    logic [3:0]  exp_cnt;

    up_down_311 #(.WIDTH(4)) dut (
        .clk_311  (clk_311),
        .reset_311(reset_311),
        .ud_311   (ud_311),
        .count_311(count_311)
    );

    // 1 ns clock: rising edges at 0.5, 1.5, ...; falling edges on whole ns.
    initial begin
        clk_311 = 1'b0;
        forever #0.5 clk_311 = ~clk_311;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge: advance the model with the direction held at the edge,
    // then compare on the following falling edge.
    task automatic step_check(input string tag);
        @(posedge clk_311);
        exp_cnt = ud_311 ? exp_cnt + 4'd1 : exp_cnt - 4'd1;
        @(negedge clk_311);
        check(tag, count_311, exp_cnt);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_311 = 1'b1;
        ud_311    = 1'b1;
        exp_cnt   = 4'd0;

        // Reset held for 8 ns while the clock runs.
        #0.25;
        check("reset_initial", count_311, 4'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_311);
            check($sformatf("reset_hold_%0d", i), count_311, 4'd0);
        end
        @(negedge clk_311);
        check("reset_at_8ns", count_311, 4'd0);

        // Release at t=8 ns, count up 100 edges (1,2,..,15,0,..) up to t=108 ns.
        reset_311 = 1'b0;
        exp_cnt   = 4'd0;
        step_check("up_first_edge");
        check("up_first_is_1", count_311, 4'd1);
        for (int i = 1; i < 16; i++) begin
            step_check($sformatf("up_%0d", i));
        end
        check("up_wrap_15_to_0", count_311, 4'd0);
        for (int i = 16; i < 100; i++) begin
            step_check($sformatf("up_%0d", i));
        end
        check("up_at_108ns", count_311, 4'd4);

        // Direction change at t=108 ns: 4 -> 3 on the very next edge.
        ud_311 = 1'b0;
        step_check("dir_change");
        check("dir_change_is_3", count_311, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step_check($sformatf("down_%0d", i));
        end
        check("down_reach_0", count_311, 4'd0);
        step_check("down_wrap");
        check("down_wrap_0_to_15", count_311, 4'd15);
        step_check("down_after_wrap");

        // Direction pulses between edges must not affect the count.
        for (int i = 0; i < 4; i++) begin
            #0.1 ud_311 = 1'b1;
            #0.2 ud_311 = 1'b0;
            step_check($sformatf("ud_glitch_%0d", i));
        end

        // Async reset between edges while the count is nonzero.
        check("pre_reset_nonzero", count_311, 4'd10);
        #0.2 reset_311 = 1'b1;
        #0.05;
        check("async_reset_immediate", count_311, 4'd0);
        @(negedge clk_311);
        check("async_reset_held_over_edge", count_311, 4'd0);
        reset_311 = 1'b0;
        exp_cnt   = 4'd0;
        ud_311    = 1'b1;
        step_check("resume_after_reset");
        check("resume_is_1", count_311, 4'd1);
        step_check("resume_up_2");

        // Reset raised exactly on a rising edge: reset wins.
        @(posedge clk_311);
        reset_311 = 1'b1;
        #0.1;
        check("reset_on_edge", count_311, 4'd0);
        @(negedge clk_311);
        check("reset_on_edge_hold", count_311, 4'd0);

        // Release with ud=0: first edge gives 15, then 3000 edges of down counting.
        ud_311    = 1'b0;
        reset_311 = 1'b0;
        exp_cnt   = 4'd0;
        step_check("down_first_edge");
        check("down_first_is_15", count_311, 4'd15);
        for (int i = 0; i < 3000; i++) begin
            step_check($sformatf("long_down_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
